demux_router: RTL

Registered 1-to-8 demultiplexer with a valid/ready handshake on every port. It is the inverse of the 8:1 `Mux` datapath: one `nBit` input stream is steered by `Sel` to one of eight output channels. Each channel owns a one-entry holding register, so a stalled channel never blocks traffic to the others. It sits between a single producer and eight independent consumers.

---
 rtl/demux_router.sv | 70 +++++++
 1 files changed

// File: rtl/demux_router.sv
// Registered 1-to-8 demultiplexer with valid/ready handshakes.
// Each output channel has a one-entry holding register, so one stalled consumer never blocks the others.
module demux_router #(
  parameter int unsigned nBit = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [nBit-1:0] in_data,
  input  logic [2:0]      Sel,
  input  logic            in_valid,
  output logic            in_ready,
  output logic [nBit-1:0] out0,
  output logic [nBit-1:0] out1,
  output logic [nBit-1:0] out2,
  output logic [nBit-1:0] out3,
  output logic [nBit-1:0] out4,
  output logic [nBit-1:0] out5,
  output logic [nBit-1:0] out6,
  output logic [nBit-1:0] out7,
  output logic [7:0]      out_valid,
  input  logic [7:0]      out_ready
);

  logic [7:0]      full_q, full_d;
  logic [nBit-1:0] data_q [8];
  logic [nBit-1:0] data_d [8];
  logic            accept;

  // A channel that drains this cycle can take a new word in the same cycle.
  assign in_ready = rst_n & (~full_q[Sel] | out_ready[Sel]);
  assign accept   = in_valid & in_ready;

  always_comb begin
    full_d = full_q;
    for (int k = 0; k < 8; k++) begin
      data_d[k] = data_q[k];
      if (accept && (Sel == 3'(k))) begin
        data_d[k] = in_data;
        full_d[k] = 1'b1;
      end else if (full_q[k] && out_ready[k]) begin
        full_d[k] = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      full_q <= '0;
      for (int k = 0; k < 8; k++) begin
        data_q[k] <= '0;
      end
    end else begin
      full_q <= full_d;
      for (int k = 0; k < 8; k++) begin
        data_q[k] <= data_d[k];
      end
    end
  end

  assign out_valid = full_q;
  assign out0      = data_q[0];
  assign out1      = data_q[1];
  assign out2      = data_q[2];
  assign out3      = data_q[3];
  assign out4      = data_q[4];
  assign out5      = data_q[5];
  assign out6      = data_q[6];
  assign out7      = data_q[7];

endmodule
